instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage that sits directly upstream of the instruction decoder.
- Holds the program counter and issues single-beat read requests to instruction memory.
- Latches the returned 16-bit word into an instruction register and drives it to the decoder with a valid flag.
- Accepts stall and branch-redirect inputs from later stages; branch_taken is normally driven from the decoder's condition_code_success.

Parameters:
- ADDR_W, 8, width of the PC and of the memory address.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, WAIT cycles before a re-request; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  one-cycle read strobe.
- mem_addr  out  ADDR_W  read address; valid while mem_req=1.
- mem_rdata  in  16  read data; sampled when mem_valid=1.
- mem_valid  in  1  read data valid; one cycle per request, latency of 1 or more cycles.
- stall  in  1  decoder/execute cannot accept a new instruction.
- branch_taken  in  1  redirect the PC this cycle.
- branch_target  in  ADDR_W  redirect address.
- instruction  out  16  instruction register, feeding the decoder's instruction input.
- instr_valid  out  1  instruction holds a live word.
- pc_out  out  ADDR_W  address of the word currently in instruction.
- fetch_err  out  1  sticky timeout flag; tied to 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset, asynchronous on rst high:
  - pc=RESET_PC, state=FETCH, squash=0.
  - instruction=16'h0000, instr_valid=0, pc_out=0, mem_req=0, mem_addr=0, fetch_err=0.
- FETCH state:
  - mem_req=1 and mem_addr=pc for exactly one cycle.
  - Next state is WAIT.
- WAIT state:
  - mem_req=0.
  - If mem_valid=1 and squash=0: instruction<=mem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+1, next state HOLD.
  - If mem_valid=1 and squash=1: discard the data, squash<=0, next state FETCH.
- HOLD state:
  - instruction and pc_out are held while stall=1.
  - When stall=0, the word is consumed that cycle: instr_valid<=0, next state FETCH.
  - Best-case throughput is one instruction per 3 cycles with 1-cycle memory latency.
- Branch, branch_taken=1 (highest priority, overrides stall):
  - pc<=branch_target and instr_valid<=0 in every state.
  - FETCH: the request already issued this cycle is stale; squash<=1, next state WAIT.
  - WAIT without mem_valid: squash<=1, stay in WAIT; the next response is dropped.
  - WAIT with mem_valid in the same cycle: the response is dropped, squash is not set, next state FETCH.
  - HOLD: next state FETCH.
- Simultaneous stall=1 and branch_taken=1 in HOLD: the branch wins.
- PC arithmetic is modulo 2^ADDR_W; all-ones+1 wraps to 0.
- mem_valid seen outside WAIT is ignored.
- rst asserted mid-request: all state clears immediately. A late mem_valid after rst is released lands in FETCH and is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter of width ceil(log2(TIMEOUT+1)) clears on entry to WAIT and increments every WAIT cycle without mem_valid.
  - When it reaches TIMEOUT: fetch_err<=1 (sticky until rst), squash<=0, next state FETCH. The same pc is re-requested.
  - A branch in the same cycle still takes priority for the pc value.
- Not defined: no counter; WAIT waits indefinitely; fetch_err is constant 0.

Test Plan:
- Reset then 1-cycle memory returning 16'hA5C3 at addr 0 -> mem_req pulses with mem_addr=0. Two cycles after rst release: instruction=16'hA5C3, instr_valid=1, pc_out=0. Next request uses mem_addr=1.
- stall=1 for 4 cycles in HOLD with instruction=16'h1234 -> instruction and pc_out are unchanged and mem_req stays 0. The first fetch happens 1 cycle after stall falls.
- branch_taken=1 with branch_target=8'h40 during FETCH, memory returning 16'hDEAD for the stale request -> 16'hDEAD is never presented. The next mem_addr is 8'h40 and its word appears with pc_out=8'h40.
- branch_taken and mem_valid in the same WAIT cycle, target 8'h10 -> response discarded, no squash set. The next request is at 8'h10 and its first response is accepted.
- PC at 8'hFF fetches successfully -> the next mem_addr is 8'h00.
- With FETCH_TIMEOUT_EN and TIMEOUT=15, mem_valid withheld -> after 15 WAIT cycles fetch_err=1 and mem_req re-pulses with the same address. fetch_err stays 1 after a later successful fetch until rst.

Source files
------------

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
// instr_fetch: fetch stage feeding the instruction decoder.
// Holds the PC, issues one-beat reads to instruction memory, latches the
// returned word into the instruction register and presents it with a valid
// flag. Branch redirects override stalls; a redirect that overtakes an
// in-flight read marks that read's response for discard (squash).
// Build option: define FETCH_TIMEOUT_EN to add a WAIT watchdog that
// re-requests the same PC after TIMEOUT silent cycles and raises the sticky
// fetch_err flag. Without it fetch_err is tied to 0.
module instr_fetch #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [15:0]       instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              squash_reg, squash_next;
  logic [15:0]       instr_reg, instr_next;
  logic              valid_reg, valid_next;
  logic [ADDR_W-1:0] pc_out_reg, pc_out_next;
  logic              timeout_hit;

  // The request strobe is the FETCH state itself; gated by rst so the bus is
  // quiet while reset is held.
  assign mem_req     = (state_reg == ST_FETCH) && !rst;
  assign mem_addr    = mem_req ? pc_reg : '0;
  assign instruction = instr_reg;
  assign instr_valid = valid_reg;
  assign pc_out      = pc_out_reg;

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          err_reg;

  // Watchdog: counts silent WAIT cycles; held at zero outside WAIT so every
  // entry to WAIT starts from zero.
  always_comb begin
    tcnt_next   = tcnt_reg;
    timeout_hit = 1'b0;
    if (state_reg == ST_WAIT && !mem_valid) begin
      tcnt_next = tcnt_reg + 1'b1;
      if (tcnt_next == TW'(TIMEOUT)) timeout_hit = 1'b1;
    end
    if (state_reg != ST_WAIT) tcnt_next = '0;
  end

  // Watchdog counter and sticky error flag, cleared only by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      tcnt_reg <= tcnt_next;
      if (timeout_hit) err_reg <= 1'b1;
    end
  end

  assign fetch_err = err_reg;
`else
  // No watchdog: WAIT waits forever and TIMEOUT has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT == 0);
  assign fetch_err   = 1'b0;
`endif

  // Next-state and datapath decisions; a taken branch overrides everything
  // else for the PC and always kills the presented word.
  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    squash_next = squash_reg;
    instr_next  = instr_reg;
    valid_next  = valid_reg;
    pc_out_next = pc_out_reg;
    case (state_reg)
      ST_FETCH: begin
        state_next = ST_WAIT;
        // The read just issued targets the old PC; drop its response.
        if (branch_taken) squash_next = 1'b1;
      end
      ST_WAIT: begin
        if (mem_valid) begin
          if (squash_reg || branch_taken) begin
            squash_next = 1'b0;
            state_next  = ST_FETCH;
          end else begin
            instr_next  = mem_rdata;
            pc_out_next = pc_reg;
            valid_next  = 1'b1;
            pc_next     = pc_reg + 1'b1;
            state_next  = ST_HOLD;
          end
        end else if (timeout_hit) begin
          squash_next = 1'b0;
          state_next  = ST_FETCH;
        end else if (branch_taken) begin
          squash_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (branch_taken || !stall) begin
          valid_next = 1'b0;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
    if (branch_taken) begin
      pc_next    = branch_target;
      valid_next = 1'b0;
    end
  end

  // State, PC and instruction register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_FETCH;
      pc_reg     <= RESET_PC;
      squash_reg <= 1'b0;
      instr_reg  <= 16'h0000;
      valid_reg  <= 1'b0;
      pc_out_reg <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      squash_reg <= squash_next;
      instr_reg  <= instr_next;
      valid_reg  <= valid_next;
      pc_out_reg <= pc_out_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
// tb_instr_fetch: directed scenarios followed by randomized stall/branch/
// latency traffic, checked every cycle against a transaction-level model of
// the fetch stage kept in this bench.
module tb_instr_fetch;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 15;

  logic              clk;
  logic              rst;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              mem_valid;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [15:0]       instruction;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_out;
  logic              fetch_err;

  int total = 0;
  int bad   = 0;

  // memory image and memory-side controls
  logic [15:0]       mem_image [256];
  int                fixed_lat;
  bit                spur_en;
  bit                mem_mute;
  bit                pend;
  int                pend_dly;
  logic [ADDR_W-1:0] pend_addr;

  // model state
  logic [ADDR_W-1:0] m_pc, m_pcout;
  logic [15:0]       m_instr;
  bit                m_want, m_out, m_dead, m_have, m_err, m_resp, m_tmo;
  int                m_wait;

  instr_fetch #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(8'h00),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .fetch_err    (fetch_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Memory: answers each request 1..4 cycles later with the image word;
  // optionally injects stray mem_valid pulses when nothing is outstanding.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = 16'h0000;
    pend      = 1'b0;
    pend_dly  = 0;
    pend_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      mem_rdata = 16'($urandom);
      if (pend) begin
        if (pend_dly <= 1) begin
          mem_valid = 1'b1;
          mem_rdata = mem_image[pend_addr];
          pend      = 1'b0;
        end else begin
          pend_dly--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_valid = 1'b1;
      end
      @(negedge clk);
      if (rst || mem_mute) begin
        pend = 1'b0;
      end else if (mem_req) begin
        pend      = 1'b1;
        pend_addr = mem_addr;
        pend_dly  = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
      end
    end
  end

  // Compare process: every cycle check the DUT against the model, then
  // advance the model by the fetch rules:
  //  - a request targets the model PC; a response is accepted only if no
  //    branch occurred from the request cycle through the response cycle;
  //  - an accepted word is presented until consumed (stall low) or killed by
  //    a branch, then the next fetch goes out;
  //  - a branch always moves the PC to its target.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        m_pc = 8'h00; m_pcout = 8'h00; m_instr = 16'h0000;
        m_want = 1'b1; m_out = 1'b0; m_dead = 1'b0; m_have = 1'b0;
        m_err = 1'b0; m_wait = 0;
      end else begin
        chk("req", 32'(mem_req), 32'(m_want));
        if (m_want) chk("addr", 32'(mem_addr), 32'(m_pc));
        chk("valid", 32'(instr_valid), 32'(m_have));
        chk("instr", 32'(instruction), 32'(m_instr));
        chk("pc_out", 32'(pc_out), 32'(m_pcout));
        chk("err", 32'(fetch_err), 32'(m_err));

        m_resp = mem_valid && m_out;
        m_tmo  = 1'b0;
        if (m_out && !mem_valid) m_wait++;
`ifdef FETCH_TIMEOUT_EN
        if (m_out && !mem_valid && m_wait == TIMEOUT) m_tmo = 1'b1;
`endif
        if (m_want) begin
          m_want = 1'b0;
          m_out  = 1'b1;
          m_wait = 0;
          m_dead = branch_taken;
        end else if (m_out) begin
          if (m_resp) begin
            m_out = 1'b0;
            if (m_dead || branch_taken) begin
              m_dead = 1'b0;
              m_want = 1'b1;
            end else begin
              m_have  = 1'b1;
              m_instr = mem_image[m_pc];
              m_pcout = m_pc;
              m_pc    = m_pc + 8'd1;
            end
          end else if (m_tmo) begin
            m_out  = 1'b0;
            m_dead = 1'b0;
            m_err  = 1'b1;
            m_want = 1'b1;
          end else if (branch_taken) begin
            m_dead = 1'b1;
          end
        end else if (m_have) begin
          if (branch_taken || !stall) begin
            m_have = 1'b0;
            m_want = 1'b1;
          end
        end
        if (branch_taken) begin
          m_pc   = branch_target;
          m_have = 1'b0;
        end
      end
    end
  end

  // Stimulus with literal expectations at key cycles.
  initial begin
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    fixed_lat = 1; spur_en = 1'b0; mem_mute = 1'b0;
    for (int i = 0; i < 256; i++) mem_image[i] = 16'($urandom);
    mem_image[8'h00] = 16'hA5C3;
    mem_image[8'h01] = 16'h1234;
    mem_image[8'h02] = 16'hDEAD;
    mem_image[8'h40] = 16'hBEEF;
    mem_image[8'h10] = 16'h7E57;
    mem_image[8'hFF] = 16'hF00D;

    // reset, first fetch at 0 with 1-cycle memory
    tick(); tick();
    @(negedge clk);
    chk("lit_rst_req", 32'(mem_req), 32'd0);
    tick(); rst = 1'b0;                               // cycle 0
    @(negedge clk);
    chk("lit_c0_req", 32'(mem_req), 32'd1);
    chk("lit_c0_addr", 32'(mem_addr), 32'h00);
    tick(); tick();                                   // cycle 2
    @(negedge clk);
    chk("lit_first_instr", 32'(instruction), 32'hA5C3);
    chk("lit_first_valid", 32'(instr_valid), 32'd1);
    chk("lit_first_pc_out", 32'(pc_out), 32'h00);
    tick();                                           // cycle 3
    @(negedge clk);
    chk("lit_next_addr", 32'(mem_addr), 32'h01);

    // stall for 4 cycles in HOLD
    tick(); stall = 1'b1;                             // cycle 4 (WAIT)
    for (int i = 0; i < 4; i++) begin                 // cycles 5..8
      tick();
      @(negedge clk);
      chk("lit_stall_instr", 32'(instruction), 32'h1234);
      chk("lit_stall_pc_out", 32'(pc_out), 32'h01);
      chk("lit_stall_req", 32'(mem_req), 32'd0);
    end
    tick(); stall = 1'b0;                             // cycle 9

    // branch during FETCH; stale 16'hDEAD must never show
    tick(); branch_taken = 1'b1; branch_target = 8'h40; // cycle 10
    @(negedge clk);
    chk("lit_after_stall_req", 32'(mem_req), 32'd1);
    chk("lit_after_stall_addr", 32'(mem_addr), 32'h02);
    tick(); branch_taken = 1'b0;                      // cycle 11
    @(negedge clk);
    chk("lit_br_valid", 32'(instr_valid), 32'd0);
    tick();                                           // cycle 12
    @(negedge clk);
    chk("lit_br_addr", 32'(mem_addr), 32'h40);
    chk("lit_br_no_dead", 32'(instruction), 32'h1234);
    tick(); tick();                                   // cycle 14
    @(negedge clk);
    chk("lit_br_instr", 32'(instruction), 32'hBEEF);
    chk("lit_br_pc_out", 32'(pc_out), 32'h40);

    // branch together with mem_valid in WAIT
    tick();                                           // cycle 15
    @(negedge clk);
    chk("lit_seq_addr", 32'(mem_addr), 32'h41);
    tick(); branch_taken = 1'b1; branch_target = 8'h10; // cycle 16
    tick(); branch_taken = 1'b0;                      // cycle 17
    @(negedge clk);
    chk("lit_brv_req", 32'(mem_req), 32'd1);
    chk("lit_brv_addr", 32'(mem_addr), 32'h10);
    tick();                                           // cycle 18
    tick(); branch_taken = 1'b1; branch_target = 8'hFF; // cycle 19
    @(negedge clk);
    chk("lit_brv_instr", 32'(instruction), 32'h7E57);
    chk("lit_brv_pc_out", 32'(pc_out), 32'h10);

    // PC wrap from 8'hFF
    tick(); branch_taken = 1'b0;                      // cycle 20
    @(negedge clk);
    chk("lit_ff_addr", 32'(mem_addr), 32'hFF);
    tick(); tick();                                   // cycle 22
    @(negedge clk);
    chk("lit_ff_instr", 32'(instruction), 32'hF00D);
    chk("lit_ff_pc_out", 32'(pc_out), 32'hFF);
    tick();                                           // cycle 23
    @(negedge clk);
    chk("lit_wrap_req", 32'(mem_req), 32'd1);
    chk("lit_wrap_addr", 32'(mem_addr), 32'h00);

    // memory goes silent
    mem_mute = 1'b1;
    do_reset();                                       // cycle 0
`ifdef FETCH_TIMEOUT_EN
    repeat (15) tick();                               // cycle 15
    @(negedge clk);
    chk("lit_to_err_before", 32'(fetch_err), 32'd0);
    chk("lit_to_req_before", 32'(mem_req), 32'd0);
    tick(); mem_mute = 1'b0;                          // cycle 16
    @(negedge clk);
    chk("lit_to_err", 32'(fetch_err), 32'd1);
    chk("lit_to_req", 32'(mem_req), 32'd1);
    chk("lit_to_addr", 32'(mem_addr), 32'h00);
    tick(); tick();                                   // cycle 18
    @(negedge clk);
    chk("lit_to_instr", 32'(instruction), 32'hA5C3);
    chk("lit_to_sticky", 32'(fetch_err), 32'd1);
`else
    repeat (40) tick();
    @(negedge clk);
    chk("lit_wait_req", 32'(mem_req), 32'd0);
    chk("lit_wait_valid", 32'(instr_valid), 32'd0);
    chk("lit_wait_err", 32'(fetch_err), 32'd0);
    mem_mute = 1'b0;
`endif
    do_reset();
    @(negedge clk);
    chk("lit_err_cleared", 32'(fetch_err), 32'd0);

    // randomized traffic
    fixed_lat = 0;
    spur_en   = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst           = ($urandom_range(0, 399) == 0);
      stall         = ($urandom_range(0, 2) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = 8'($urandom);
    end
    tick();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
